pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control.sv | 131 +++++++++++++
 tb/tb_pipeline_control.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - pipeline hazard control: per-register enables, flushes, valid tracking, multi-cycle hold, perf counters
module pipeline_control #(
   parameter int STAGES    = 4,
   parameter int BRU_IDX   = 1,
   parameter int JUMP_IDX  = 0,
   parameter int MC_IDX    = 1,
   parameter int MC_WIDTH  = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clock_in,
   input  logic                 reset_in,
   input  logic                 fetch_valid_in,
   input  logic [STAGES-1:0]    stall_req_in,
   input  logic                 bru_flush_in,
   input  logic                 jump_flush_in,
   input  logic                 mc_start_in,
   input  logic [MC_WIDTH-1:0]  mc_cycles_in,
   output logic                 pc_enable_out,
   output logic [STAGES-1:0]    stage_enable_out,
   output logic [STAGES-1:0]    stage_flush_out,
   output logic [STAGES-1:0]    valid_out,
   output logic                 mc_busy_out,
   output logic [CNT_WIDTH-1:0] stall_count_out,
   output logic [CNT_WIDTH-1:0] flush_count_out
);

   logic [STAGES-1:0]    r_valid;
   logic [MC_WIDTH-1:0]  r_mc_cnt;
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_flush_cnt;

   logic                 w_mc_busy;
   logic                 w_any_flush;
   logic [STAGES-1:0]    w_flush_mask;
   logic [STAGES-1:0]    w_active;
   logic [STAGES-1:0]    w_enable;
   logic [STAGES-1:0]    w_flush;
   logic                 w_pc_en;
   logic [STAGES:0]      w_valid_src;
   logic [STAGES-1:0]    w_valid_nxt;

   assign w_mc_busy   = (r_mc_cnt != '0);
   assign w_any_flush = bru_flush_in | jump_flush_in;
   // Fetch valid sits just above the youngest register so every stage shifts from index i+1
   assign w_valid_src = {fetch_valid_in, r_valid};

   // Hold point, bubble and flush decode; a flush cancels every stall in the same cycle
   always_comb begin
      int  h;
      logic found;
      h            = 0;
      found        = 1'b0;
      w_active     = '0;
      w_flush_mask = '0;
      w_enable     = '1;
      w_flush      = '0;
      w_pc_en      = 1'b1;
      for (int i = 0; i < STAGES; i++) begin
         w_active[i]     = stall_req_in[i] | ((i == MC_IDX) & w_mc_busy);
         w_flush_mask[i] = (bru_flush_in & (i >= BRU_IDX)) | (jump_flush_in & (i >= JUMP_IDX));
      end
      for (int i = STAGES - 1; i >= 0; i--) begin
         if (w_active[i]) begin
            h     = i;
            found = 1'b1;
         end
      end
      if (w_any_flush) begin
         w_flush = w_flush_mask;
      end else if (found) begin
         w_pc_en = 1'b0;
         for (int i = 0; i < STAGES; i++) begin
            if (i >= h) w_enable[i] = 1'b0;
            if (i == h - 1) w_flush[i] = 1'b1;
         end
      end
   end

   // Next valid bits: flush clears, enable shifts from the younger neighbour, hold keeps
   always_comb begin
      w_valid_nxt = r_valid;
      for (int i = 0; i < STAGES; i++) begin
         if (w_flush[i]) w_valid_nxt[i] = 1'b0;
         else if (w_enable[i]) w_valid_nxt[i] = w_valid_src[i+1];
      end
   end

   // Valid tracking register
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) r_valid <= '0;
      else r_valid <= w_valid_nxt;
   end

   // Multi-cycle hold counter: flush clears it, busy counts down, idle start loads it
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) r_mc_cnt <= '0;
      else if (w_any_flush) r_mc_cnt <= '0;
      else if (w_mc_busy) r_mc_cnt <= r_mc_cnt - MC_WIDTH'(1);
      else if (mc_start_in) r_mc_cnt <= mc_cycles_in;
   end

   // Saturating performance counters for stalled-PC cycles and flush cycles
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!w_pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
         if (w_any_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
      end
   end

   // Reset forces everything flushed and enabled with the PC frozen
   always_comb begin
      if (!reset_in) begin
         pc_enable_out    = 1'b0;
         stage_enable_out = '1;
         stage_flush_out  = '1;
      end else begin
         pc_enable_out    = w_pc_en;
         stage_enable_out = w_enable;
         stage_flush_out  = w_flush;
      end
   end

   assign valid_out       = r_valid;
   assign mc_busy_out     = w_mc_busy;
   assign stall_count_out = r_stall_cnt;
   assign flush_count_out = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - directed self-checking bench for pipeline_control
module tb_pipeline_control;

   logic        clock_in;
   logic        reset_in;
   logic        fetch_valid_in;
   logic [3:0]  stall_req_in;
   logic        bru_flush_in;
   logic        jump_flush_in;
   logic        mc_start_in;
   logic [3:0]  mc_cycles_in;
   logic        pc_enable_out;
   logic [3:0]  stage_enable_out;
   logic [3:0]  stage_flush_out;
   logic [3:0]  valid_out;
   logic        mc_busy_out;
   logic [15:0] stall_count_out;
   logic [15:0] flush_count_out;

   logic        s_pc_enable;
   logic [3:0]  s_enable;
   logic [3:0]  s_flush;
   logic [3:0]  s_valid;
   logic        s_busy;
   logic [1:0]  s_stall_cnt;
   logic [1:0]  s_flush_cnt;

   int total = 0;
   int bad   = 0;

   pipeline_control dut (
      .clock_in(clock_in), .reset_in(reset_in), .fetch_valid_in(fetch_valid_in),
      .stall_req_in(stall_req_in), .bru_flush_in(bru_flush_in), .jump_flush_in(jump_flush_in),
      .mc_start_in(mc_start_in), .mc_cycles_in(mc_cycles_in), .pc_enable_out(pc_enable_out),
      .stage_enable_out(stage_enable_out), .stage_flush_out(stage_flush_out), .valid_out(valid_out),
      .mc_busy_out(mc_busy_out), .stall_count_out(stall_count_out), .flush_count_out(flush_count_out)
   );

   pipeline_control #(.CNT_WIDTH(2)) dut_sat (
      .clock_in(clock_in), .reset_in(reset_in), .fetch_valid_in(fetch_valid_in),
      .stall_req_in(stall_req_in), .bru_flush_in(bru_flush_in), .jump_flush_in(jump_flush_in),
      .mc_start_in(mc_start_in), .mc_cycles_in(mc_cycles_in), .pc_enable_out(s_pc_enable),
      .stage_enable_out(s_enable), .stage_flush_out(s_flush), .valid_out(s_valid),
      .mc_busy_out(s_busy), .stall_count_out(s_stall_cnt), .flush_count_out(s_flush_cnt)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_in);
      #1;
   endtask

   initial begin
      reset_in       = 1'b1;
      fetch_valid_in = 1'b0;
      stall_req_in   = 4'b0000;
      bru_flush_in   = 1'b0;
      jump_flush_in  = 1'b0;
      mc_start_in    = 1'b0;
      mc_cycles_in   = 4'd0;
      #1 reset_in = 1'b0;
      tick();
      tick();

      chk("rst_valid", 32'(valid_out), 32'h0);
      chk("rst_flush", 32'(stage_flush_out), 32'hF);
      chk("rst_enable", 32'(stage_enable_out), 32'hF);
      chk("rst_pc", 32'(pc_enable_out), 32'h0);
      chk("rst_busy", 32'(mc_busy_out), 32'h0);
      chk("rst_stall_cnt", 32'(stall_count_out), 32'h0);
      chk("rst_flush_cnt", 32'(flush_count_out), 32'h0);

      // fill the pipe
      reset_in       = 1'b1;
      fetch_valid_in = 1'b1;
      #1;
      chk("run_pc", 32'(pc_enable_out), 32'h1);
      chk("run_enable", 32'(stage_enable_out), 32'hF);
      chk("run_flush", 32'(stage_flush_out), 32'h0);
      tick(); chk("fill1", 32'(valid_out), 32'h8);
      tick(); chk("fill2", 32'(valid_out), 32'hC);
      tick(); chk("fill3", 32'(valid_out), 32'hE);
      tick(); chk("fill4", 32'(valid_out), 32'hF);
      chk("fill_stall_cnt", 32'(stall_count_out), 32'h0);

      // single-cycle stall at register 2
      stall_req_in = 4'b0100;
      #1;
      chk("stall_enable", 32'(stage_enable_out), 32'h3);
      chk("stall_flush", 32'(stage_flush_out), 32'h2);
      chk("stall_pc", 32'(pc_enable_out), 32'h0);
      tick();
      stall_req_in = 4'b0000;
      chk("stall_cnt1", 32'(stall_count_out), 32'h1);
      chk("stall_valid", 32'(valid_out), 32'hD);

      // branch flush beats a stall
      bru_flush_in = 1'b1;
      stall_req_in = 4'b1000;
      #1;
      chk("bru_flush", 32'(stage_flush_out), 32'hE);
      chk("bru_enable", 32'(stage_enable_out), 32'hF);
      chk("bru_pc", 32'(pc_enable_out), 32'h1);
      tick();
      bru_flush_in = 1'b0;
      stall_req_in = 4'b0000;
      chk("bru_flush_cnt", 32'(flush_count_out), 32'h1);
      chk("bru_valid", 32'(valid_out), 32'h0);
      chk("bru_stall_cnt", 32'(stall_count_out), 32'h1);

      // refill
      for (int i = 0; i < 4; i++) tick();
      chk("refill", 32'(valid_out), 32'hF);

      // multi-cycle op of 3 cycles, second start ignored
      mc_start_in  = 1'b1;
      mc_cycles_in = 4'd3;
      #1;
      chk("mc_start_busy", 32'(mc_busy_out), 32'h0);
      chk("mc_start_enable", 32'(stage_enable_out), 32'hF);
      tick();
      mc_cycles_in = 4'd5;
      #1;
      chk("mc_h1_busy", 32'(mc_busy_out), 32'h1);
      chk("mc_h1_enable", 32'(stage_enable_out), 32'h1);
      chk("mc_h1_flush", 32'(stage_flush_out), 32'h1);
      chk("mc_h1_pc", 32'(pc_enable_out), 32'h0);
      tick();
      mc_start_in = 1'b0;
      chk("mc_h2_busy", 32'(mc_busy_out), 32'h1);
      chk("mc_h2_enable", 32'(stage_enable_out), 32'h1);
      tick();
      chk("mc_h3_busy", 32'(mc_busy_out), 32'h1);
      tick();
      chk("mc_end_busy", 32'(mc_busy_out), 32'h0);
      chk("mc_end_enable", 32'(stage_enable_out), 32'hF);
      chk("mc_end_stall_cnt", 32'(stall_count_out), 32'h4);
      chk("mc_end_valid", 32'(valid_out), 32'hE);

      // zero-length op produces no hold
      mc_start_in  = 1'b1;
      mc_cycles_in = 4'd0;
      tick();
      mc_start_in = 1'b0;
      chk("mc0_busy", 32'(mc_busy_out), 32'h0);
      chk("mc0_pc", 32'(pc_enable_out), 32'h1);

      // jump flush aborts an active hold
      mc_start_in  = 1'b1;
      mc_cycles_in = 4'd5;
      tick();
      mc_start_in   = 1'b0;
      jump_flush_in = 1'b1;
      #1;
      chk("jmp_busy_before", 32'(mc_busy_out), 32'h1);
      chk("jmp_flush", 32'(stage_flush_out), 32'hF);
      chk("jmp_enable", 32'(stage_enable_out), 32'hF);
      chk("jmp_pc", 32'(pc_enable_out), 32'h1);
      tick();
      jump_flush_in = 1'b0;
      chk("jmp_busy_after", 32'(mc_busy_out), 32'h0);
      chk("jmp_flush_cnt", 32'(flush_count_out), 32'h2);
      chk("jmp_stall_cnt", 32'(stall_count_out), 32'h4);

      // both flushes: union of masks
      bru_flush_in  = 1'b1;
      jump_flush_in = 1'b1;
      #1;
      chk("both_flush", 32'(stage_flush_out), 32'hF);
      tick();
      bru_flush_in  = 1'b0;
      jump_flush_in = 1'b0;
      chk("both_flush_cnt", 32'(flush_count_out), 32'h3);

      // asynchronous reset in the middle of a hold
      mc_start_in  = 1'b1;
      mc_cycles_in = 4'd6;
      tick();
      mc_start_in = 1'b0;
      chk("arst_busy_before", 32'(mc_busy_out), 32'h1);
      #2 reset_in = 1'b0;
      #1;
      chk("arst_busy", 32'(mc_busy_out), 32'h0);
      chk("arst_pc", 32'(pc_enable_out), 32'h0);
      chk("arst_valid", 32'(valid_out), 32'h0);
      chk("arst_stall_cnt", 32'(stall_count_out), 32'h0);
      chk("arst_flush_cnt", 32'(flush_count_out), 32'h0);
      tick();
      reset_in = 1'b1;

      // saturation on the 2-bit counter instance
      chk("sat_start", 32'(s_stall_cnt), 32'h0);
      stall_req_in = 4'b0001;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk($sformatf("sat_cnt%0d", i), 32'(s_stall_cnt), (i > 3) ? 32'h3 : 32'(i));
         chk($sformatf("wide_cnt%0d", i), 32'(stall_count_out), 32'(i));
      end
      stall_req_in = 4'b0000;
      tick();
      chk("sat_hold", 32'(s_stall_cnt), 32'h3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
